// File: rtl/program_loader.sv
// Serial boot loader: receives a word-count header and 32-bit words over an 8N1 line
// and writes them into instruction memory, holding the CPU in reset until loading is complete.
module program_loader #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        rx,
  output logic        mem_wen,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_data,
  output logic        cpu_clr,
  output logic        done,
  output logic        err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [1:0] HDR  = 2'd0;
  localparam logic [1:0] WORD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  logic          rx_s1, rx_s2, rx_prev;
  logic [1:0]    rx_state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_byte;
  logic          byte_ok, frame_err;

  logic [1:0]    state;
  logic [1:0]    byte_idx;
  logic [23:0]   word_sr;
  logic [7:0]    last_idx;

  // Sync flops reset high so releasing clr never looks like a falling start edge.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Start needs a real high-to-low edge, so a held-low break yields only one frame.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rx_state <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      rx_byte  <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= RX_START;
            cnt      <= '0;
          end
        end
        RX_START: begin
          if (cnt == CNT_HALF) begin
            cnt      <= '0;
            bit_idx  <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == CNT_FULL) begin
            cnt     <= '0;
            rx_byte <= {rx_s2, rx_byte[7:1]};
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
            else                 bit_idx  <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (cnt == CNT_FULL) begin
            cnt      <= '0;
            rx_state <= RX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign byte_ok   = (rx_state == RX_STOP) && (cnt == CNT_FULL) &&  rx_s2;
  assign frame_err = (rx_state == RX_STOP) && (cnt == CNT_FULL) && !rx_s2;

  // last_idx holds N-1, so a header of 0 naturally becomes 255 (256 words).
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= HDR;
      mem_wen  <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      byte_idx <= '0;
      word_sr  <= '0;
      last_idx <= '0;
    end else begin
      mem_wen <= 1'b0;
      if (mem_wen) begin
        mem_addr <= mem_addr + 8'd1;
        if (mem_addr == last_idx) state <= DONE;
      end
      case (state)
        HDR: begin
          if (frame_err) begin
            state <= ERR;
          end else if (byte_ok) begin
            last_idx <= rx_byte - 8'd1;
            byte_idx <= '0;
            state    <= WORD;
          end
        end
        WORD: begin
          if (frame_err) begin
            state <= ERR;
          end else if (byte_ok) begin
            word_sr  <= {word_sr[15:0], rx_byte};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              mem_wen  <= 1'b1;
              mem_data <= {word_sr, rx_byte};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign done    = (state == DONE);
  assign err     = (state == ERR);
  assign cpu_clr = (state != DONE);

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: serial frames in, memory write pulses recorded and
// compared against hand-computed addresses and words.
module tb_program_loader;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        rx  = 1'b1;
  logic        mem_wen;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data;
  logic        cpu_clr, done, err;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  wen_addr[$];
  logic [31:0] wen_data[$];

  program_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .clr      (clr),
    .rx       (rx),
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .cpu_clr  (cpu_clr),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Every cycle with mem_wen high is logged, so a stretched strobe shows up as an extra write.
  always @(negedge clk) begin
    if (mem_wen === 1'b1) begin
      wen_addr.push_back(mem_addr);
      wen_data.push_back(mem_data);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic sendWord(input logic [31:0] w);
    applyStimulus(w[31:24], 1'b1);
    applyStimulus(w[23:16], 1'b1);
    applyStimulus(w[15:8],  1'b1);
    applyStimulus(w[7:0],   1'b1);
  endtask

  task automatic doReset();
    @(negedge clk);
    clr = 1'b0;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    repeat (3) @(negedge clk);
    wen_addr.delete();
    wen_data.delete();
  endtask

  initial begin
    // Outputs while held in reset
    repeat (3) @(negedge clk);
    checkOutput("rst_wen",     {31'd0, mem_wen}, 32'd0);
    checkOutput("rst_addr",    {24'd0, mem_addr}, 32'd0);
    checkOutput("rst_data",    mem_data, 32'd0);
    checkOutput("rst_cpu_clr", {31'd0, cpu_clr}, 32'd1);
    checkOutput("rst_done",    {31'd0, done}, 32'd0);
    checkOutput("rst_err",     {31'd0, err}, 32'd0);
    clr = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("release_no_write", wen_addr.size(), 32'd0);

    // Two-word program
    applyStimulus(8'h02, 1'b1);
    sendWord(32'h8C010004);
    sendWord(32'h00221820);
    repeat (10) @(negedge clk);
    checkOutput("two_count", wen_addr.size(), 32'd2);
    if (wen_addr.size() >= 2) begin
      checkOutput("two_addr0", {24'd0, wen_addr[0]}, 32'd0);
      checkOutput("two_data0", wen_data[0], 32'h8C010004);
      checkOutput("two_addr1", {24'd0, wen_addr[1]}, 32'd1);
      checkOutput("two_data1", wen_data[1], 32'h00221820);
    end
    checkOutput("two_done",    {31'd0, done}, 32'd1);
    checkOutput("two_cpu_clr", {31'd0, cpu_clr}, 32'd0);
    checkOutput("two_err",     {31'd0, err}, 32'd0);

    // Extra bytes after completion are ignored
    sendWord(32'hCAFEF00D);
    repeat (10) @(negedge clk);
    checkOutput("done_count", wen_addr.size(), 32'd2);
    checkOutput("done_stay",  {31'd0, done}, 32'd1);
    checkOutput("done_addr",  {24'd0, mem_addr}, 32'd2);

    // Asynchronous reset takes effect before any clock edge
    @(negedge clk);
    clr = 1'b0;
    #1;
    checkOutput("async_done",    {31'd0, done}, 32'd0);
    checkOutput("async_cpu_clr", {31'd0, cpu_clr}, 32'd1);
    checkOutput("async_addr",    {24'd0, mem_addr}, 32'd0);
    checkOutput("async_data",    mem_data, 32'd0);
    doReset();

    // Reset in the middle of a word discards the partial data
    applyStimulus(8'h01, 1'b1);
    applyStimulus(8'hDE, 1'b1);
    applyStimulus(8'hAD, 1'b1);
    @(negedge clk);
    rx = 1'b0;
    repeat (6) @(negedge clk);
    doReset();
    checkOutput("midrst_no_write", wen_addr.size(), 32'd0);
    applyStimulus(8'h01, 1'b1);
    sendWord(32'hDEADBEEF);
    repeat (10) @(negedge clk);
    checkOutput("midrst_count", wen_addr.size(), 32'd1);
    if (wen_addr.size() >= 1) begin
      checkOutput("midrst_addr", {24'd0, wen_addr[0]}, 32'd0);
      checkOutput("midrst_data", wen_data[0], 32'hDEADBEEF);
    end
    checkOutput("midrst_done", {31'd0, done}, 32'd1);

    // Framing error on the second data byte
    doReset();
    applyStimulus(8'h01, 1'b1);
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("ferr_err",     {31'd0, err}, 32'd1);
    checkOutput("ferr_cpu_clr", {31'd0, cpu_clr}, 32'd1);
    checkOutput("ferr_done",    {31'd0, done}, 32'd0);
    sendWord(32'h11223344);
    sendWord(32'h55667788);
    repeat (10) @(negedge clk);
    checkOutput("ferr_no_write", wen_addr.size(), 32'd0);
    checkOutput("ferr_sticky",   {31'd0, err}, 32'd1);

    // Short low glitch while waiting for the header
    doReset();
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("glitch_err", {31'd0, err}, 32'd0);
    applyStimulus(8'h01, 1'b1);
    sendWord(32'h12345678);
    repeat (10) @(negedge clk);
    checkOutput("glitch_count", wen_addr.size(), 32'd1);
    if (wen_addr.size() >= 1) begin
      checkOutput("glitch_addr", {24'd0, wen_addr[0]}, 32'd0);
      checkOutput("glitch_data", wen_data[0], 32'h12345678);
    end
    checkOutput("glitch_done", {31'd0, done}, 32'd1);

    // Line held low (break) after the header
    doReset();
    applyStimulus(8'h01, 1'b1);
    @(negedge clk);
    rx = 1'b0;
    repeat (30 * CPB) @(negedge clk);
    checkOutput("break_err",      {31'd0, err}, 32'd1);
    checkOutput("break_cpu_clr",  {31'd0, cpu_clr}, 32'd1);
    checkOutput("break_no_write", wen_addr.size(), 32'd0);
    rx = 1'b1;

    // Header 0 loads 256 words, value = index
    doReset();
    applyStimulus(8'h00, 1'b1);
    for (int i = 0; i < 256; i++) begin
      sendWord(32'(i));
      if (i == 254) checkOutput("n256_not_done_early", {31'd0, done}, 32'd0);
    end
    repeat (10) @(negedge clk);
    checkOutput("n256_count", wen_addr.size(), 32'd256);
    for (int i = 0; i < wen_addr.size(); i++) begin
      checkOutput($sformatf("n256_addr%0d", i), {24'd0, wen_addr[i]}, 32'(i));
      checkOutput($sformatf("n256_data%0d", i), wen_data[i], 32'(i));
    end
    checkOutput("n256_done",    {31'd0, done}, 32'd1);
    checkOutput("n256_cpu_clr", {31'd0, cpu_clr}, 32'd0);
    checkOutput("n256_wrap",    {24'd0, mem_addr}, 32'd0);
    sendWord(32'hFFFFFFFF);
    repeat (10) @(negedge clk);
    checkOutput("n256_no_extra", wen_addr.size(), 32'd256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit (even, >= 4).
REQ-002 The block SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 The block SHALL have port clr  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-004 The block SHALL have port rx  input  1  asynchronous serial line, 8N1, idle high, LSB first.
REQ-005 The block SHALL have port mem_wen  output  1  one-cycle write strobe to instruction memory.
REQ-006 The block SHALL have port mem_addr  output  8  instruction memory word index.
REQ-007 The block SHALL have port mem_data  output  32  instruction word to write.
REQ-008 The block SHALL have port cpu_clr  output  1  processor hold, high while loading or after error.
REQ-009 The block SHALL have port done  output  1  load complete, sticky until reset.
REQ-010 The block SHALL have port err  output  1  framing error, sticky until reset.

Function
REQ-011 rx SHALL pass a 2-flop synchronizer; all receiver timing below refers to the synchronized signal.
REQ-012 Receiver SHALL detect start on synchronized rx high-to-low, re-check low at CLKS_PER_BIT/2 cycles later (high -> abandon, return to idle, no error), then sample 8 data bits and stop bit each CLKS_PER_BIT cycles after.
REQ-013 Stop bit sampled 0 SHALL be a framing error; stop bit 1 SHALL accept the byte in that sample cycle.
REQ-014 Loader FSM SHALL have states HDR, WORD, DONE, ERR; reset state HDR.
REQ-015 HDR: first accepted byte SHALL be word count N; N=0 means 256 words; transition to WORD.
REQ-016 WORD: bytes SHALL assemble words MSB first (byte 0 -> mem_data[31:24], byte 3 -> [7:0]).
REQ-017 On acceptance of the 4th byte of a word, mem_wen SHALL be 1 in the next cycle only, with mem_addr = word index and mem_data = full word stable in that cycle.
REQ-018 mem_addr SHALL increment by 1 in the cycle after each mem_wen; 8-bit wrap 255 -> 0 SHALL occur only after the 256th word and is not used for a further write.
REQ-019 After the Nth word's mem_wen cycle, FSM SHALL enter DONE: done=1, cpu_clr=0 from the following cycle.
REQ-020 DONE SHALL ignore rx; no further mem_wen until reset.
REQ-021 Framing error in HDR or WORD SHALL enter ERR: err=1, cpu_clr stays 1, partial word discarded, rx ignored, no further mem_wen until reset.
REQ-022 A break (rx held low) SHALL produce exactly one framing error, not repeated start detection.
REQ-023 mem_wen SHALL never be asserted outside WORD-state word completion.

Reset
REQ-024 clr=0 SHALL immediately force: mem_wen=0, mem_addr=0, mem_data=0, cpu_clr=1, done=0, err=0, FSM=HDR, receiver idle, synchronizer flops=1.
REQ-025 Reset mid-byte or mid-word SHALL discard all partial data; after clr=1 the loader SHALL wait for a new header.
REQ-026 Release of clr SHALL not create a false start bit.

Verification
REQ-027 Header 0x02, words 0x8C010004, 0x00221820 -> two mem_wen pulses, (addr 0, 0x8C010004), (addr 1, 0x00221820); done=1, cpu_clr=0 after second pulse.
REQ-028 Header 0x00, 256 words value=index -> 256 pulses addr 0..255, data 0..255, done=1, no 257th pulse.
REQ-029 Header 0x01, second data byte with stop bit 0 -> err=1, cpu_clr=1, no mem_wen; subsequent valid bytes ignored.
REQ-030 rx low glitch of CLKS_PER_BIT/4 cycles in HDR -> no byte accepted, err=0, next valid header accepted normally.
REQ-031 clr=0 after 2 bytes of first word, then clr=1, header 0x01, word 0xDEADBEEF -> single pulse addr 0, data 0xDEADBEEF.
REQ-032 In DONE, send 4 more bytes -> no mem_wen, done stays 1, mem_addr unchanged.
